// File: rtl/qpu_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | qpu_pkg : shared QPU instruction format, opcodes and sequencer state type    |
// | Revision: 1.0                                                                |
// +-----------------------------------------------------------------------------+
package qpu_pkg;

  localparam int INSTR_W = 16;
  localparam int FIELD_W = 4;
  localparam int OP_LSB  = 12;
  localparam int TGT_LSB = 8;
  localparam int CTL_LSB = 4;
  localparam int PRM_LSB = 0;

  localparam logic [FIELD_W-1:0] HALT_OP = 4'hF;
  localparam logic [FIELD_W-1:0] OP_NOP  = 4'h0;
  localparam logic [FIELD_W-1:0] OP_X    = 4'h1;
  localparam logic [FIELD_W-1:0] OP_H    = 4'h2;
  localparam logic [FIELD_W-1:0] OP_CNOT = 4'h3;
  localparam logic [FIELD_W-1:0] OP_Z    = 4'h4;
  localparam logic [FIELD_W-1:0] OP_MEAS = 4'h5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2,
    DONE  = 2'd3
  } seq_state_t;

  function automatic logic [FIELD_W-1:0] opcode_of(input logic [INSTR_W-1:0] word);
    return word[OP_LSB +: FIELD_W];
  endfunction

endpackage
`default_nettype wire

// File: rtl/qpu_instr_sequencer_if.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | qpu_instr_sequencer_if : valid/ready instruction channel to the gate core    |
// | Revision: 1.0                                                                |
// +-----------------------------------------------------------------------------+
interface qpu_instr_sequencer_if;
  import qpu_pkg::*;

  logic               instr_valid;
  logic [INSTR_W-1:0] instr_data;
  logic               instr_ready;

  modport master (output instr_valid, output instr_data, input  instr_ready);
  modport slave  (input  instr_valid, input  instr_data, output instr_ready);

endinterface
`default_nettype wire

// File: rtl/qpu_prog_mem.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | qpu_prog_mem : DEPTH x DATA_W program store, one write port, one sync read   |
// | Revision: 1.0                                                                |
// +-----------------------------------------------------------------------------+
module qpu_prog_mem #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int DATA_W = 16
) (
  input  wire logic              clk,
  input  wire logic              i_wr_en,
  input  wire logic [ADDR_W-1:0] i_wr_addr,
  input  wire logic [DATA_W-1:0] i_wr_data,
  input  wire logic [ADDR_W-1:0] i_rd_addr,
  output logic      [DATA_W-1:0] o_rd_data
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rd_data;

  // Contents are deliberately left unreset so the array maps onto block RAM.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
    r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/qpu_instr_sequencer.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | qpu_instr_sequencer : fetches the loaded program and issues it to the core   |
// | Revision: 1.0                                                                |
// +-----------------------------------------------------------------------------+
module qpu_instr_sequencer
  import qpu_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  wire logic                clk,
  input  wire logic                reset,
  input  wire logic                wr_en,
  input  wire logic [ADDR_W-1:0]   wr_addr,
  input  wire logic [INSTR_W-1:0]  wr_data,
  input  wire logic [ADDR_W:0]     prog_len,
  input  wire logic                start,
  qpu_instr_sequencer_if.master    core_if,
  output logic      [ADDR_W-1:0]   pc,
  output logic      [ADDR_W:0]     issued_cnt,
  output logic                     busy,
  output logic                     done,
  output logic                     error
);

  localparam int                LEN_W     = ADDR_W + 1;
  localparam logic [LEN_W-1:0]  c_len_one = LEN_W'(1);
  localparam logic [LEN_W-1:0]  c_depth   = LEN_W'(DEPTH);

  seq_state_t          r_state, w_state_nxt;
  logic [ADDR_W-1:0]   r_pc, w_pc_nxt;
  logic [LEN_W-1:0]    r_len, w_len_nxt;
  logic [LEN_W-1:0]    r_cnt, w_cnt_nxt;
  logic                r_valid, w_valid_nxt;
  logic [INSTR_W-1:0]  r_data, w_data_nxt;
  logic                r_err, w_err_nxt;
  logic                r_done, w_done_nxt;
  logic                w_mem_we;
  logic                w_len_ok;
  logic                w_last;
  logic [INSTR_W-1:0]  w_rd_data;

  qpu_prog_mem #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (INSTR_W)
  ) u_prog_mem (
    .clk       (clk),
    .i_wr_en   (w_mem_we),
    .i_wr_addr (wr_addr),
    .i_wr_data (wr_data),
    .i_rd_addr (r_pc),
    .o_rd_data (w_rd_data)
  );

  assign w_mem_we = wr_en && (r_state == IDLE);
  assign w_len_ok = (prog_len != '0) && (prog_len <= c_depth);
  assign w_last   = (({1'b0, r_pc} + c_len_one) == r_len);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_pc    <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_err   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_len   <= w_len_nxt;
      r_cnt   <= w_cnt_nxt;
      r_valid <= w_valid_nxt;
      r_data  <= w_data_nxt;
      r_err   <= w_err_nxt;
      r_done  <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_len_nxt   = r_len;
    w_cnt_nxt   = r_cnt;
    w_valid_nxt = r_valid;
    w_data_nxt  = r_data;
    w_err_nxt   = r_err;
    w_done_nxt  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          if (w_len_ok) begin
            w_state_nxt = FETCH;
            w_pc_nxt    = '0;
            w_len_nxt   = prog_len;
            w_cnt_nxt   = '0;
            w_err_nxt   = 1'b0;
          end else begin
            w_err_nxt  = 1'b1;
            w_done_nxt = 1'b1;
          end
        end
      end
      FETCH: begin
        w_state_nxt = ISSUE;
      end
      ISSUE: begin
        // First ISSUE cycle inspects the fetched word; later cycles wait for ready.
        if (!r_valid) begin
          if (opcode_of(w_rd_data) == HALT_OP) begin
            w_state_nxt = DONE;
            w_done_nxt  = 1'b1;
          end else begin
            w_valid_nxt = 1'b1;
            w_data_nxt  = w_rd_data;
          end
        end else if (core_if.instr_ready) begin
          w_valid_nxt = 1'b0;
          w_cnt_nxt   = r_cnt + c_len_one;
          if (w_last) begin
            w_state_nxt = DONE;
            w_done_nxt  = 1'b1;
          end else begin
            w_pc_nxt    = r_pc + ADDR_W'(1);
            w_state_nxt = FETCH;
          end
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign core_if.instr_valid = r_valid;
  assign core_if.instr_data  = r_data;
  assign pc                  = r_pc;
  assign issued_cnt          = r_cnt;
  assign busy                = (r_state != IDLE);
  assign done                = r_done;
  assign error               = r_err;

endmodule
`default_nettype wire

// File: tb/tb_qpu_instr_sequencer.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_qpu_instr_sequencer : directed self-checking bench for the sequencer      |
// | Revision: 1.0                                                                |
// +-----------------------------------------------------------------------------+
module tb_qpu_instr_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;
  logic [4:0]  prog_len;
  logic        start;
  logic [3:0]  pc;
  logic [4:0]  issued_cnt;
  logic        busy;
  logic        done;
  logic        error;

  qpu_instr_sequencer_if bus ();

  qpu_instr_sequencer #(.DEPTH(16), .ADDR_W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .prog_len   (prog_len),
    .start      (start),
    .core_if    (bus.master),
    .pc         (pc),
    .issued_cnt (issued_cnt),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Results gathered by run_collect for the calling test to judge.
  logic [15:0] acc_q [$];
  int first_valid, done_cnt, k_done, busy_after, stall_seen, stall_bad, halt_valid, timeout;

  task automatic write_word(input logic [3:0] a, input logic [15:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic load_prog3();
    write_word(4'd0, 16'h1100);
    write_word(4'd1, 16'h2210);
    write_word(4'd2, 16'h3300);
  endtask

  // Pulses start and records every accepted word; k counts samples after the start edge.
  task automatic run_collect(input logic [4:0] len, input int stall_idx, input int stall_n,
                             input int wr_k, input logic [3:0] wr_a, input logic [15:0] wr_d);
    int stall_left;
    logic [15:0] stall_ref;
    acc_q.delete();
    first_valid = -1; done_cnt = 0; k_done = -1; busy_after = -1;
    stall_seen = 0; stall_bad = 0; halt_valid = 0; timeout = 1;
    stall_left = stall_n; stall_ref = '0;
    prog_len = len; start = 1'b1; bus.instr_ready = 1'b1;
    if (wr_k == -1) begin
      wr_en = 1'b1; wr_addr = wr_a; wr_data = wr_d;
    end
    for (int k = 0; k < 200; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      wr_en = (k == wr_k);
      if (k == wr_k) begin
        wr_addr = wr_a; wr_data = wr_d;
      end
      if (bus.instr_valid && first_valid < 0) first_valid = k;
      if (bus.instr_valid && bus.instr_data[15:12] == 4'hF) halt_valid++;
      if (done) begin
        done_cnt++;
        if (k_done < 0) k_done = k;
      end
      if (k_done >= 0 && k == k_done + 1) busy_after = int'(busy);
      if (stall_left > 0 && stall_left < stall_n && !bus.instr_valid) stall_bad++;
      if (bus.instr_valid && acc_q.size() == stall_idx && stall_left > 0) begin
        if (stall_left == stall_n) stall_ref = bus.instr_data;
        else if (bus.instr_data !== stall_ref) stall_bad++;
        stall_left--;
        stall_seen++;
        bus.instr_ready = 1'b0;
      end else begin
        bus.instr_ready = 1'b1;
      end
      if (bus.instr_valid && bus.instr_ready) acc_q.push_back(bus.instr_data);
      if (k_done >= 0 && k >= k_done + 2) begin
        timeout = 0;
        break;
      end
    end
    bus.instr_ready = 1'b1; wr_en = 1'b0; start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", bus.instr_valid); end
    checks++; if (bus.instr_data !== 16'h0) begin errors++; $display("FAIL reset_data got %h want 0000", bus.instr_data); end
    checks++; if (pc !== 4'd0) begin errors++; $display("FAIL reset_pc got %0d want 0", pc); end
    checks++; if (issued_cnt !== 5'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", issued_cnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL reset_error got %b want 0", error); end
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    load_prog3();
    run_collect(5'd3, -1, 0, -2, 4'd0, 16'h0);
    checks++; if (timeout != 0) begin errors++; $display("FAIL basic_timeout got %0d want 0", timeout); end
    checks++; if (acc_q.size() != 3) begin errors++; $display("FAIL basic_count got %0d want 3", acc_q.size()); end
    if (acc_q.size() == 3) begin
      checks++; if (acc_q[0] !== 16'h1100) begin errors++; $display("FAIL basic_w0 got %h want 1100", acc_q[0]); end
      checks++; if (acc_q[1] !== 16'h2210) begin errors++; $display("FAIL basic_w1 got %h want 2210", acc_q[1]); end
      checks++; if (acc_q[2] !== 16'h3300) begin errors++; $display("FAIL basic_w2 got %h want 3300", acc_q[2]); end
    end
    checks++; if (first_valid != 2) begin errors++; $display("FAIL basic_latency got %0d want 2", first_valid); end
    checks++; if (k_done != 9) begin errors++; $display("FAIL basic_done_cycle got %0d want 9", k_done); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL basic_done_pulses got %0d want 1", done_cnt); end
    checks++; if (issued_cnt !== 5'd3) begin errors++; $display("FAIL basic_issued got %0d want 3", issued_cnt); end
    checks++; if (busy_after != 0) begin errors++; $display("FAIL basic_busy_after got %0d want 0", busy_after); end
    checks++; if (pc !== 4'd2) begin errors++; $display("FAIL basic_pc got %0d want 2", pc); end
  endtask

  task automatic test_stall();
    run_collect(5'd3, 1, 5, -2, 4'd0, 16'h0);
    checks++; if (timeout != 0) begin errors++; $display("FAIL stall_timeout got %0d want 0", timeout); end
    checks++; if (acc_q.size() != 3) begin errors++; $display("FAIL stall_count got %0d want 3", acc_q.size()); end
    if (acc_q.size() >= 2) begin
      checks++; if (acc_q[1] !== 16'h2210) begin errors++; $display("FAIL stall_w1 got %h want 2210", acc_q[1]); end
    end
    checks++; if (stall_seen != 5) begin errors++; $display("FAIL stall_held got %0d want 5", stall_seen); end
    checks++; if (stall_bad != 0) begin errors++; $display("FAIL stall_stable got %0d want 0", stall_bad); end
    checks++; if (issued_cnt !== 5'd3) begin errors++; $display("FAIL stall_issued got %0d want 3", issued_cnt); end
  endtask

  task automatic test_halt();
    write_word(4'd1, 16'hF000);
    run_collect(5'd3, -1, 0, -2, 4'd0, 16'h0);
    checks++; if (timeout != 0) begin errors++; $display("FAIL halt_timeout got %0d want 0", timeout); end
    checks++; if (acc_q.size() != 1) begin errors++; $display("FAIL halt_count got %0d want 1", acc_q.size()); end
    if (acc_q.size() >= 1) begin
      checks++; if (acc_q[0] !== 16'h1100) begin errors++; $display("FAIL halt_w0 got %h want 1100", acc_q[0]); end
    end
    checks++; if (halt_valid != 0) begin errors++; $display("FAIL halt_presented got %0d want 0", halt_valid); end
    checks++; if (issued_cnt !== 5'd1) begin errors++; $display("FAIL halt_issued got %0d want 1", issued_cnt); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL halt_done_pulses got %0d want 1", done_cnt); end
    checks++; if (k_done != 5) begin errors++; $display("FAIL halt_done_cycle got %0d want 5", k_done); end
  endtask

  task automatic test_write_start();
    run_collect(5'd1, -1, 0, -1, 4'd0, 16'h4400);
    checks++; if (acc_q.size() != 1) begin errors++; $display("FAIL wrstart_count got %0d want 1", acc_q.size()); end
    if (acc_q.size() >= 1) begin
      checks++; if (acc_q[0] !== 16'h4400) begin errors++; $display("FAIL wrstart_w0 got %h want 4400", acc_q[0]); end
    end
  endtask

  task automatic test_error();
    load_prog3();
    run_collect(5'd0, -1, 0, -2, 4'd0, 16'h0);
    checks++; if (error !== 1'b1) begin errors++; $display("FAIL err_len0 got %b want 1", error); end
    checks++; if (first_valid != -1) begin errors++; $display("FAIL err_len0_valid got %0d want -1", first_valid); end
    checks++; if (k_done != 0) begin errors++; $display("FAIL err_len0_done_cycle got %0d want 0", k_done); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL err_len0_done_pulses got %0d want 1", done_cnt); end
    checks++; if (busy_after != 0) begin errors++; $display("FAIL err_len0_busy got %0d want 0", busy_after); end
    run_collect(5'd17, -1, 0, -2, 4'd0, 16'h0);
    checks++; if (error !== 1'b1) begin errors++; $display("FAIL err_len17 got %b want 1", error); end
    checks++; if (first_valid != -1) begin errors++; $display("FAIL err_len17_valid got %0d want -1", first_valid); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL err_len17_done_pulses got %0d want 1", done_cnt); end
    run_collect(5'd1, -1, 0, -2, 4'd0, 16'h0);
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL err_cleared got %b want 0", error); end
    checks++; if (acc_q.size() != 1) begin errors++; $display("FAIL err_recover_count got %0d want 1", acc_q.size()); end
  endtask

  task automatic test_wr_protect();
    run_collect(5'd3, -1, 0, 1, 4'd1, 16'hAAAA);
    if (acc_q.size() >= 2) begin
      checks++; if (acc_q[1] !== 16'h2210) begin errors++; $display("FAIL prot_run1_w1 got %h want 2210", acc_q[1]); end
    end else begin
      checks++; errors++; $display("FAIL prot_run1_count got %0d want 3", acc_q.size());
    end
    run_collect(5'd3, -1, 0, -2, 4'd0, 16'h0);
    if (acc_q.size() >= 2) begin
      checks++; if (acc_q[1] !== 16'h2210) begin errors++; $display("FAIL prot_run2_w1 got %h want 2210", acc_q[1]); end
    end else begin
      checks++; errors++; $display("FAIL prot_run2_count got %0d want 3", acc_q.size());
    end
  endtask

  task automatic test_reset_midrun();
    int n;
    int got;
    int stray_done;
    n = 0; got = 0; stray_done = 0;
    prog_len = 5'd3; bus.instr_ready = 1'b1; start = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (bus.instr_valid) begin
        if (n == 1) begin
          bus.instr_ready = 1'b0;
          got = 1;
          break;
        end
        n++;
      end
    end
    checks++; if (got != 1) begin errors++; $display("FAIL rst_mid_reach got %0d want 1", got); end
    checks++; if (pc !== 4'd1) begin errors++; $display("FAIL rst_mid_pc_before got %0d want 1", pc); end
    #2 reset = 1'b0;
    #1;
    checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid got %b want 0", bus.instr_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got %b want 0", busy); end
    checks++; if (pc !== 4'd0) begin errors++; $display("FAIL rst_mid_pc got %0d want 0", pc); end
    @(posedge clk); #1;
    reset = 1'b1; bus.instr_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (done) stray_done++;
    end
    checks++; if (stray_done != 0) begin errors++; $display("FAIL rst_mid_done got %0d want 0", stray_done); end
    run_collect(5'd3, -1, 0, -2, 4'd0, 16'h0);
    checks++; if (acc_q.size() != 3) begin errors++; $display("FAIL rst_restart_count got %0d want 3", acc_q.size()); end
    if (acc_q.size() >= 1) begin
      checks++; if (acc_q[0] !== 16'h1100) begin errors++; $display("FAIL rst_restart_w0 got %h want 1100", acc_q[0]); end
    end
  endtask

  initial begin
    reset = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    prog_len = '0; start = 1'b0; bus.instr_ready = 1'b1;
    test_reset();
    test_basic();
    test_stall();
    test_halt();
    test_write_start();
    test_error();
    test_wr_protect();
    test_reset_midrun();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
